// File: rtl/alu_exec_unit.sv
// 24-bit EX-stage ALU: single-cycle logic/arith/shift ops plus an iterative shift-add MUL.
// Optional: define MUL_EARLY_TERM_EN to end MUL as soon as the remaining multiplier is zero.
module alu_exec_unit #(
   parameter int WIDTH   = 24,
   parameter int SHAMT_W = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Operation,
   input  logic             Bnegate,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t               r_state, w_state_nxt;
   logic [WIDTH-1:0]     r_mcand, r_mplier, r_result;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_done, r_zero, r_ovf;

   logic [WIDTH-1:0]     w_bop, w_sum, w_diff, w_sll, w_mplier_nxt, w_res_nxt;
   logic [SHAMT_W-1:0]   w_shamt;
   logic                 w_slt, w_add_ovf, w_ovf_nxt, w_complete, w_mul_load, w_mul_step, w_mul_last;
   logic [2*WIDTH-1:0]   w_addend, w_acc_nxt;

   // Single-cycle datapath
   assign w_bop     = Bnegate ? ~B : B;
   assign w_sum     = A + w_bop + {{(WIDTH-1){1'b0}}, Bnegate};
   assign w_add_ovf = (A[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
   assign w_diff    = A - B;
   // Differing signs decide SLT directly, so the subtraction can never overflow the answer.
   assign w_slt     = (A[WIDTH-1] ^ B[WIDTH-1]) ? A[WIDTH-1] : w_diff[WIDTH-1];
   assign w_shamt   = B[SHAMT_W-1:0];
   assign w_sll     = (int'(w_shamt) >= WIDTH) ? '0 : (A << w_shamt);

   // One shift-add step of the multiplier
   assign w_addend     = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
   assign w_acc_nxt    = r_acc + w_addend;
   assign w_mplier_nxt = r_mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
   assign w_mul_last   = (w_mplier_nxt == '0);
`else
   assign w_mul_last   = (r_cnt == CNT_W'(WIDTH-1));
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_complete  = 1'b0;
      w_mul_load  = 1'b0;
      w_mul_step  = 1'b0;
      w_res_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               if (Operation == OP_MUL) begin
                  w_mul_load  = 1'b1;
                  w_state_nxt = S_MUL;
               end else begin
                  w_complete = 1'b1;
                  case (Operation)
                     OP_AND:  w_res_nxt = A & B;
                     OP_OR:   w_res_nxt = A | B;
                     OP_ADD: begin
                        w_res_nxt = w_sum;
                        w_ovf_nxt = w_add_ovf;
                     end
                     OP_SLT:  w_res_nxt = {{(WIDTH-1){1'b0}}, w_slt};
                     OP_XOR:  w_res_nxt = A ^ B;
                     OP_SLL:  w_res_nxt = w_sll;
                     default: w_res_nxt = '0;
                  endcase
               end
            end
         end
         S_MUL: begin
            w_mul_step = 1'b1;
            if (w_mul_last) begin
               w_complete  = 1'b1;
               w_res_nxt   = w_acc_nxt[WIDTH-1:0];
               w_ovf_nxt   = |w_acc_nxt[2*WIDTH-1:WIDTH];
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_done   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         r_done <= w_complete;
         if (w_complete) begin
            r_result <= w_res_nxt;
            r_zero   <= (w_res_nxt == '0);
            r_ovf    <= w_ovf_nxt;
         end
         if (w_mul_load) begin
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else if (w_mul_step) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + 1'b1;
         end
      end
   end

   assign Busy     = (r_state == S_MUL);
   assign Done     = r_done;
   assign Result   = r_result;
   assign Zero     = r_zero;
   assign Overflow = r_ovf;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes model results, a monitor checks each Done.
module tb_alu_exec_unit;
   logic        Clock = 1'b0, Reset = 1'b1, Start = 1'b0, Bnegate = 1'b0;
   logic [2:0]  Operation = 3'd0;
   logic [23:0] A = '0, B = '0;
   logic        Busy, Done, Zero, Overflow;
   logic [23:0] Result;

   alu_exec_unit dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Operation(Operation), .Bnegate(Bnegate),
      .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero), .Overflow(Overflow)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      logic [23:0] res;
      logic        ovf;
      int          cyc;
   } exp_t;
   exp_t q[$];

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sx(input logic [23:0] v);
      return v[23] ? int'(v) - 16777216 : int'(v);
   endfunction

   // Reference model from the arithmetic rules, independent of the RTL structure
   function automatic void model(input logic [2:0] op, input logic bn, input logic [23:0] a,
                                 input logic [23:0] b, output logic [23:0] res,
                                 output logic ovf, output int steps);
      int s;
      longint p;
      int sh;
      res = '0; ovf = 1'b0; steps = 0;
      case (op)
         3'd0: res = a & b;
         3'd1: res = a | b;
         3'd2: begin
            s   = bn ? sx(a) - sx(b) : sx(a) + sx(b);
            p   = bn ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
            res = p[23:0];
            ovf = (s > 8388607) || (s < -8388608);
         end
         3'd3: res = (sx(a) < sx(b)) ? 24'd1 : 24'd0;
         3'd4: begin
            p   = longint'(a) * longint'(b);
            res = p[23:0];
            ovf = (p >> 24) != 0;
`ifdef MUL_EARLY_TERM_EN
            steps = 1;
            for (int i = 0; i < 24; i++) if (b[i]) steps = i + 1;
`else
            steps = 24;
`endif
         end
         3'd5: res = a ^ b;
         3'd6: begin
            sh  = int'(b[4:0]);
            p   = longint'(a) << sh;
            res = (sh >= 24) ? 24'd0 : p[23:0];
         end
         default: res = '0;
      endcase
   endfunction

   // Monitor: every Done must match the oldest expectation; otherwise outputs must hold
   logic [23:0] last_res = '0;
   logic        last_zero = 1'b1, last_ovf = 1'b0;
   always @(negedge Clock) begin
      exp_t e;
      if (Reset) begin
         last_res = '0; last_zero = 1'b1; last_ovf = 1'b0;
      end else if (Done) begin
         if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: result %0h with nothing pending (cycle %0d)", Result, cyc);
         end else begin
            e = q.pop_front();
            chk("result", 48'(Result), 48'(e.res));
            chk("zero", 48'(Zero), 48'(e.res == 24'd0));
            chk("overflow", 48'(Overflow), 48'(e.ovf));
            chk("done_cycle", 48'(cyc), 48'(e.cyc));
            last_res = e.res; last_zero = (e.res == 24'd0); last_ovf = e.ovf;
         end
      end else begin
         chk("hold_result", 48'(Result), 48'(last_res));
         chk("hold_flags", 48'({Zero, Overflow}), 48'({last_zero, last_ovf}));
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (Busy && t < 200) begin @(negedge Clock); t++; end
      if (Busy) chk("busy_timeout", 48'(Busy), 48'(0));
   endtask

   task automatic issue(input logic [2:0] op, input logic bn, input logic [23:0] a, input logic [23:0] b);
      exp_t e;
      int   steps;
      wait_idle();
      model(op, bn, a, b, e.res, e.ovf, steps);
      e.cyc = cyc + 1 + steps;
      q.push_back(e);
      Start = 1'b1; Operation = op; Bnegate = bn; A = a; B = b;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_result"}, 48'(Result), 48'(0));
      chk({tag, "_flags"}, 48'({Busy, Done, Zero, Overflow}), 48'(4'b0010));
   endtask

   initial begin
      int t;
      repeat (3) @(negedge Clock);
      chk_reset_outputs("reset");
      Reset = 1'b0;
      @(negedge Clock);

      issue(3'd2, 1'b0, 24'h7FFFFF, 24'h000001);   // ADD signed overflow
      issue(3'd2, 1'b1, 24'd5, 24'd5);             // SUB to zero
      issue(3'd2, 1'b1, 24'h800000, 24'd1);        // SUB signed overflow
      issue(3'd3, 1'b0, 24'hFFFFFF, 24'd1);        // SLT -1 < 1
      issue(3'd3, 1'b1, 24'd1, 24'hFFFFFF);
      issue(3'd6, 1'b0, 24'd1, 24'd23);
      issue(3'd6, 1'b0, 24'd1, 24'd24);
      issue(3'd6, 1'b0, 24'hABCDEF, 24'hFFFF1F);
      issue(3'd5, 1'b0, 24'hFF00FF, 24'h0F0F0F);
      issue(3'd0, 1'b1, 24'hF0F0F0, 24'h3C3C3C);
      issue(3'd1, 1'b0, 24'h00F000, 24'h0000F0);
      issue(3'd7, 1'b0, 24'h123456, 24'h654321);   // reserved

      issue(3'd4, 1'b0, 24'd1000, 24'd3000);
      @(negedge Clock);                            // Start while Busy must be ignored
      Start = 1'b1; Operation = 3'd2; A = 24'h111111; B = 24'h222222;
      @(negedge Clock);
      Operation = 3'd4;
      @(negedge Clock);
      Start = 1'b0;
      issue(3'd4, 1'b0, 24'h001000, 24'h001000);
      issue(3'd4, 1'b0, 24'h345678, 24'd1);
      issue(3'd4, 1'b0, 24'h345678, 24'd0);
      issue(3'd4, 1'b0, 24'h000007, 24'h000005);
      issue(3'd4, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
      issue(3'd2, 1'b0, 24'd10, 24'd20);           // back-to-back after MUL Done

      // Reset in the middle of a MUL
      issue(3'd4, 1'b0, 24'h123456, 24'hFFFFFF);
      repeat (5) @(negedge Clock);
      #2 Reset = 1'b1;
      #1 chk_reset_outputs("midmul_reset");
      q.delete();
      @(negedge Clock);
      @(negedge Clock);
      #2 Reset = 1'b0;
      repeat (30) @(negedge Clock);

      for (int i = 0; i < 150; i++) begin
         logic [23:0] a, b;
         logic [2:0]  op;
         a  = 24'($urandom);
         b  = 24'($urandom);
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) b = 24'($urandom_range(0, 31));
         issue(op, 1'($urandom), a, b);
         if ($urandom_range(0, 2) == 0) @(negedge Clock);
      end

      t = 0;
      while (q.size() > 0 && t < 100) begin @(negedge Clock); t++; end
      chk("drain_pending", 48'(q.size()), 48'(0));
      @(negedge Clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle 24-bit ALU datapath. Consumes the {Operation, Bnegate} code produced by the ALU control decoder and executes it.
- Logic, add/sub, set-less-than, shift and XOR complete in one cycle. MUL runs on an iterative shift-add engine.
- Sits in the EX stage. The CPU control sequencer stalls on Busy and captures Result on Done.

Parameters:
- WIDTH, 24, operand/result width in bits; fixed at 24 in this CPU.
- SHAMT_W, 5, number of low bits of B used as the shift amount.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only while Busy=0.
- Operation  input  3  op code: 000 AND, 001 OR, 010 ADD/SUB, 011 SLT, 100 MUL, 101 XOR, 110 SLL, 111 reserved.
- Bnegate  input  1  1 = subtract (A-B) when Operation=010; ignored for all other codes.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Busy  output  1  high while a MUL is iterating.
- Done  output  1  one-cycle pulse when Result is valid.
- Result  output  WIDTH  registered result; holds until the next completion.
- Zero  output  1  registered (Result==0); updates with Result.
- Overflow  output  1  registered; updates with Result.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high; ports are named Clock and Reset.
- Reset values: state=IDLE; Busy=0, Done=0, Result=0, Zero=1, Overflow=0; internal multiplicand, multiplier, accumulator and counter all 0.
- States: IDLE and MUL.
- IDLE, Start=1, Operation≠100:
  - Compute on that edge.
  - Done=1 for the following cycle. Latency is 1; the FSM stays in IDLE.
- IDLE, Start=1, Operation=100:
  - Latch A into the multiplicand, B into the multiplier, clear the accumulator (2*WIDTH bits), counter=0.
  - Go to MUL; Busy=1 from the next cycle. Done=0.
- MUL, each edge:
  - If multiplier[0]=1, add the multiplicand (shifted by the counter) into the accumulator.
  - Shift the multiplier right by 1; counter+1.
  - After the 24th step: Result=acc[23:0], Overflow=(acc[47:24]≠0), Busy=0, Done=1, return to IDLE.
  - Done is therefore high in the cycle after the 24th MUL edge.
- Start while Busy=1: ignored. Operands are not re-latched and there is no error indication.
- Back-to-back: Start in the cycle where Done=1 is accepted. Done may stay high on consecutive cycles, one pulse per operation.
- Arithmetic rules:
  - ADD: A+B modulo 2^24. Overflow = signed overflow (operands have equal signs, result sign differs).
  - SUB: A+~B+1. Overflow = signed overflow (operand signs differ, result sign differs from A).
  - AND/OR/XOR: bitwise. Overflow=0.
  - SLT: signed compare A<B, Result = 24'd1 or 24'd0. Uses subtraction regardless of Bnegate. Overflow=0.
  - SLL: A << B[4:0]. Shift amounts 24..31 give 0. Overflow=0.
  - MUL: unsigned 24x24; low 24 bits returned; Overflow as defined above.
  - 111 reserved: Result=0, Zero=1, Overflow=0, Done still pulses.
- Reset mid-MUL: immediately abort to IDLE. All outputs return to their reset values; no Done pulse is issued.
- Result, Zero and Overflow change only on a completion edge, or on Reset.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN
- Defined:
  - MUL completes on the first MUL edge whose post-shift multiplier is 0.
  - Example: B=0 or B=1 gives Done in the cycle after the first MUL edge. B=0x000005 completes after 3 steps.
  - Result and Overflow are identical to the full-length computation.
- Undefined: MUL always takes exactly 24 MUL edges, independent of B.

Test Plan:
- Reset, then check outputs: Result=0, Zero=1, Overflow=0, Busy=0, Done=0. Assert Reset during a MUL → same values, no Done.
- ADD A=0x7FFFFF, B=0x000001 → Result 0x800000, Overflow=1, Done one cycle after Start.
- SUB A=5, B=5 (Bnegate=1) → Result 0, Zero=1. SLT A=0xFFFFFF, B=1 → Result 1.
- SLL A=1, B=23 → 0x800000. SLL A=1, B=24 → 0, Zero=1. XOR A=0xFF00FF, B=0x0F0F0F → 0xF00FF0.
- MUL A=1000, B=3000 → Result 0x2DC6C0, Overflow=0, Done 24 cycles after the MUL state is entered (macro off). Start pulsed mid-MUL is ignored.
- MUL A=0x001000, B=0x001000 → Result 0, Overflow=1. With MUL_EARLY_TERM_EN defined, B=1 → Done after a single MUL edge, Result=A.
